// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered round-robin / forced-select bus source mux.
// Ports:
//   clk, clr         : clock, synchronous active-high reset
//   req              : per-source bus request (bit i = source i)
//   data_in          : flattened source words, source i at [i*WIDTH +: WIDTH]
//   force_en         : control-unit override of arbitration
//   force_sel        : source index used while force_en=1
//   bus_out          : registered bus word
//   bus_valid        : bus_out carries data of a granted source
//   grant            : registered one-hot grant (zero when idle)
//   grant_idx        : registered index of the granted source (0 when idle)
module bus_arbiter_mux #(
  parameter int WIDTH    = 32,
  parameter int NUM_SRC  = 24,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic                     force_en,
  input  logic [SEL_W-1:0]         force_sel,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [NUM_SRC-1:0]       grant,
  output logic [SEL_W-1:0]         grant_idx
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state;
  state_t             nState;
  logic [SEL_W-1:0]   rrPtr;
  logic [SEL_W-1:0]   nPtr;
  logic [HW-1:0]      holdCnt;
  logic [HW-1:0]      nHold;
  logic [HW-1:0]      holdEff;
  logic               forced;
  logic               nForced;
  logic [WIDTH-1:0]   busReg;
  logic [WIDTH-1:0]   nBus;
  logic               validReg;
  logic [NUM_SRC-1:0] grantReg;
  logic [NUM_SRC-1:0] nGrant;
  logic [SEL_W-1:0]   idxReg;
  logic [SEL_W-1:0]   nIdx;

  logic               selHit;
  logic [SEL_W-1:0]   selIdx;
  logic [NUM_SRC-1:0] others;
  logic               expire;
  logic               relBus;
  logic [SEL_W-1:0]   nextPtr;
  logic               idleHit;
  logic [SEL_W-1:0]   idleW;
  logic               handHit;
  logic [SEL_W-1:0]   handW;

  logic [WIDTH-1:0]   src [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : gUnpack
    assign src[i] = data_in[i*WIDTH +: WIDTH];
  end

  function automatic logic [NUM_SRC-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    logic [NUM_SRC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Cyclic priority scan starting at 'start'.
  function automatic void arb(
    input  logic [NUM_SRC-1:0] r,
    input  logic [SEL_W-1:0]   start,
    output logic               hit,
    output logic [SEL_W-1:0]   idx
  );
    int pi;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pi = int'(start) + k;
      if (pi >= NUM_SRC) pi = pi - NUM_SRC;
      if (!hit && r[pi[SEL_W-1:0]]) begin
        hit = 1'b1;
        idx = pi[SEL_W-1:0];
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      rrPtr    <= '0;
      holdCnt  <= '0;
      forced   <= 1'b0;
      busReg   <= '0;
      validReg <= 1'b0;
      grantReg <= '0;
      idxReg   <= '0;
    end else begin
      state    <= nState;
      rrPtr    <= nPtr;
      holdCnt  <= nHold;
      forced   <= nForced;
      busReg   <= nBus;
      validReg <= selHit;
      grantReg <= nGrant;
      idxReg   <= nIdx;
    end
  end

  always_comb begin
    nState  = state;
    nPtr    = rrPtr;
    nHold   = holdCnt;
    nForced = forced;
    selHit  = 1'b0;
    selIdx  = '0;

    // A grant inherited from a forced select starts its hold count at 0.
    holdEff = forced ? '0 : holdCnt;
    others  = req & ~onehot(idxReg);
    expire  = (int'(holdEff) >= MAX_HOLD) && (others != '0);
    relBus  = !req[idxReg] || expire;
    nextPtr = (int'(idxReg) == NUM_SRC - 1) ? '0 : idxReg + 1'b1;

    arb(req, rrPtr, idleHit, idleW);
    // 'others' already drops the owner; for a plain release req[g]=0.
    arb(others, nextPtr, handHit, handW);

    if (force_en) begin
      if (int'(force_sel) < NUM_SRC) begin
        selHit  = 1'b1;
        selIdx  = force_sel;
        nState  = BUSY;
        nForced = 1'b1;
      end else begin
        nState  = IDLE;
        nForced = 1'b0;
      end
    end else begin
      nForced = 1'b0;
      unique case (state)
        IDLE: begin
          if (idleHit) begin
            selHit = 1'b1;
            selIdx = idleW;
            nHold  = HW'(1);
            nState = BUSY;
          end
        end
        BUSY: begin
          if (!relBus) begin
            selHit = 1'b1;
            selIdx = idxReg;
            nHold  = (int'(holdEff) < MAX_HOLD) ?
                     holdEff + HW'(1) : holdEff;
          end else begin
            nPtr = nextPtr;
            if (handHit) begin
              selHit = 1'b1;
              selIdx = handW;
              nHold  = HW'(1);
            end else begin
              nState = IDLE;
              nHold  = '0;
            end
          end
        end
        default: nState = IDLE;
      endcase
    end

    nBus   = selHit ? src[selIdx] : '0;
    nGrant = selHit ? onehot(selIdx) : '0;
    nIdx   = selHit ? selIdx : '0;
  end

  assign bus_out   = busReg;
  assign bus_valid = validReg;
  assign grant     = grantReg;
  assign grant_idx = idxReg;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: table vectors, directed sequences and random
// stimulus against a behavioural model of the bus arbiter.
module tb_bus_arbiter_mux;

  localparam int W  = 32;
  localparam int N  = 24;
  localparam int SW = 5;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic [N-1:0]  req;
  logic [N*W-1:0] dataIn;
  logic          forceEn;
  logic [SW-1:0] forceSel;
  logic [W-1:0]  busOut;
  logic          busValid;
  logic [N-1:0]  grant;
  logic [SW-1:0] grantIdx;

  logic [W-1:0]  src [N];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : gPack
    assign dataIn[i*W +: W] = src[i];
  end

  bus_arbiter_mux #(
    .WIDTH(W), .NUM_SRC(N), .SEL_W(SW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .clr(clr), .req(req), .data_in(dataIn),
    .force_en(forceEn), .force_sel(forceSel),
    .bus_out(busOut), .bus_valid(busValid),
    .grant(grant), .grant_idx(grantIdx)
  );

  int nVec = 0;
  int nBad = 0;

  // Behavioural model: owner index (-1 = idle), pointer, hold count.
  int          mOwner = -1;
  int          mPtr   = 0;
  int          mHold  = 0;
  bit          mFF    = 0;
  logic [W-1:0] mBus  = '0;

  function automatic int arbm(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic modelStep();
    logic [N-1:0] one;
    logic [N-1:0] oth;
    int h, w, g;
    bit rel;
    one = 1;
    if (clr) begin
      mOwner = -1; mPtr = 0; mHold = 0; mFF = 0; mBus = '0;
    end else if (forceEn) begin
      if (int'(forceSel) < N) begin
        mOwner = int'(forceSel); mFF = 1; mBus = src[mOwner];
      end else begin
        mOwner = -1; mFF = 0; mBus = '0;
      end
    end else if (mOwner < 0) begin
      w = arbm(req, mPtr);
      mFF = 0;
      if (w >= 0) begin
        mOwner = w; mHold = 1; mBus = src[w];
      end else begin
        mBus = '0;
      end
    end else begin
      g   = mOwner;
      h   = mFF ? 0 : mHold;
      oth = req & ~(one << g);
      rel = !req[g] || (h >= MH && oth != 0);
      mFF = 0;
      if (!rel) begin
        mHold = (h + 1 > MH) ? MH : h + 1;
        mBus  = src[g];
      end else begin
        mPtr = (g + 1) % N;
        w = arbm(oth, mPtr);
        if (w >= 0) begin
          mOwner = w; mHold = 1; mBus = src[w];
        end else begin
          mOwner = -1; mBus = '0;
        end
      end
    end
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      nBad++;
    end
  endtask

  task automatic check();
    logic [N-1:0] one;
    one = 1;
    nVec++;
    cmp("bus_out", busOut, mBus);
    cmp("bus_valid", 32'(busValid), 32'(mOwner >= 0));
    cmp("grant", 32'(grant), mOwner < 0 ? 32'd0 : 32'(one << mOwner));
    cmp("grant_idx", 32'(grantIdx), mOwner < 0 ? 32'd0 : mOwner);
    cmp("rr_ptr", 32'(dut.rrPtr), mPtr);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    check();
  endtask

  task automatic doReset();
    clr = 1'b1; req = '0; forceEn = 1'b0; forceSel = '0;
    cycle();
    clr = 1'b0;
  endtask

  typedef struct {
    bit           c;
    logic [N-1:0] r;
    bit           fen;
    logic [SW-1:0] fsel;
    bit           expV;
    int           expIdx;
    int           expPtr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    clr = 1'b1; req = '0; forceEn = 1'b0; forceSel = '0;
    for (int i = 0; i < N; i++) src[i] = 32'h1000_0000 + 32'(i) * 32'h0101;

    tbl[0]  = '{1, 24'h0,      0, 5'd0,  0, 0,  0};
    tbl[1]  = '{0, 24'h0,      0, 5'd0,  0, 0,  0};
    tbl[2]  = '{0, 24'h20,     0, 5'd0,  1, 5,  0};
    tbl[3]  = '{0, 24'hA0,     0, 5'd0,  1, 5,  0};
    tbl[4]  = '{0, 24'h80,     0, 5'd0,  1, 7,  6};
    tbl[5]  = '{0, 24'h0,      0, 5'd0,  0, 0,  8};
    tbl[6]  = '{0, 24'h408,    0, 5'd0,  1, 10, 8};
    tbl[7]  = '{0, 24'h408,    1, 5'd21, 1, 21, 8};
    tbl[8]  = '{0, 24'h408,    1, 5'd30, 0, 0,  8};
    tbl[9]  = '{0, 24'h408,    0, 5'd0,  1, 10, 8};
    tbl[10] = '{1, 24'h408,    0, 5'd0,  0, 0,  0};
    tbl[11] = '{0, 24'h408,    0, 5'd0,  1, 3,  0};
    tbl[12] = '{0, 24'h800000, 0, 5'd0,  1, 23, 4};
    tbl[13] = '{0, 24'h800001, 0, 5'd0,  1, 23, 4};
    tbl[14] = '{0, 24'h000001, 0, 5'd0,  1, 0,  0};
    tbl[15] = '{0, 24'h0,      0, 5'd0,  0, 0,  1};

    for (int v = 0; v < 16; v++) begin
      clr = tbl[v].c; req = tbl[v].r;
      forceEn = tbl[v].fen; forceSel = tbl[v].fsel;
      cycle();
      cmp("tbl_valid", 32'(busValid), 32'(tbl[v].expV));
      cmp("tbl_idx", 32'(grantIdx), tbl[v].expIdx);
      cmp("tbl_ptr", 32'(dut.rrPtr), tbl[v].expPtr);
      cmp("tbl_bus", busOut, tbl[v].expV ? src[tbl[v].expIdx] : 32'd0);
    end

    // Reset mid-grant.
    doReset();
    req = 24'h8;
    cycle();
    clr = 1'b1;
    cycle();
    cmp("rst_valid", 32'(busValid), 0);
    cmp("rst_grant", 32'(grant), 0);
    cmp("rst_ptr", 32'(dut.rrPtr), 0);
    clr = 1'b0;
    cycle();
    cmp("rst_regrant", 32'(grantIdx), 3);

    // Basic latency and data tracking.
    doReset();
    src[5] = 32'hDEAD_BEEF;
    req = 24'h20;
    cycle();
    cmp("lat_idx", 32'(grantIdx), 5);
    cmp("lat_bus", busOut, 32'hDEAD_BEEF);
    src[5] = 32'h1234_5678;
    cycle();
    cmp("lat_track", busOut, 32'h1234_5678);

    // Round-robin between 0 and 23 with hold expiry and wrap.
    doReset();
    req = 24'h800001;
    for (int c = 0; c < 24; c++) begin
      cycle();
      cmp("rr_idx", 32'(grantIdx), (c < 8 || c >= 16) ? 0 : 23);
      cmp("rr_valid", 32'(busValid), 1);
      if (c == 16) cmp("rr_wrap_ptr", 32'(dut.rrPtr), 0);
    end

    // Release handover.
    doReset();
    req = 24'h4;
    cycle();
    req = 24'h80;
    cycle();
    cmp("ho_idx", 32'(grantIdx), 7);
    cmp("ho_valid", 32'(busValid), 1);
    cmp("ho_bus", busOut, src[7]);
    cmp("ho_ptr", 32'(dut.rrPtr), 3);

    // Force override, invalid select, then force falling.
    doReset();
    req = 24'h10;
    cycle();
    src[21] = 32'hA5A5_A5A5;
    forceEn = 1'b1; forceSel = 5'd21;
    cycle();
    cmp("frc_grant", 32'(grant), 32'h20_0000);
    cmp("frc_bus", busOut, 32'hA5A5_A5A5);
    cmp("frc_ptr", 32'(dut.rrPtr), 0);
    forceSel = 5'd30;
    cycle();
    cmp("frc_bad_bus", busOut, 0);
    cmp("frc_bad_valid", 32'(busValid), 0);
    cmp("frc_bad_grant", 32'(grant), 0);
    forceSel = 5'd21;
    cycle();
    forceEn = 1'b0;
    req = 24'h20_0010;
    cycle();
    cmp("frc_fall_idx", 32'(grantIdx), 21);
    cmp("frc_fall_hold", 32'(dut.holdCnt), 1);

    // Sole requester never expires.
    doReset();
    req = 24'h200;
    for (int c = 0; c < 20; c++) begin
      cycle();
      cmp("sole_idx", 32'(grantIdx), 9);
    end
    cmp("sole_hold", 32'(dut.holdCnt), MH);

    // Randomised traffic against the model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      clr = ($urandom_range(99) == 0);
      if ($urandom_range(1) == 0) begin
        for (int b = 0; b < N; b++) req[b] = ($urandom_range(5) == 0);
      end
      forceEn  = ($urandom_range(11) == 0);
      forceSel = SW'($urandom_range(31));
      src[$urandom_range(N - 1)] = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
